apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, APB address width.
REQ-003 SHALL have parameter NREQ, default 4, requester count (fixed at 4 in this revision).
REQ-004 SHALL have port pclk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port prst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  in  NREQ  per-requester request, held until req_ack.
REQ-007 SHALL have port req_write  in  NREQ  per-requester direction (1 = write).
REQ-008 SHALL have port req_psel  in  2*NREQ  per-requester slave code.
REQ-009 SHALL have port req_addr  in  ADDR_WIDTH*NREQ  per-requester address.
REQ-010 SHALL have port req_wdata  in  DATA_WIDTH*NREQ  per-requester write data.
REQ-011 SHALL have port req_ack  out  NREQ  one-cycle grant/accept pulse.
REQ-012 SHALL have port req_done  out  NREQ  one-cycle completion pulse.
REQ-013 SHALL have port req_err  out  1  qualifies req_done; 1 = rejected request.
REQ-014 SHALL have port rdata  out  DATA_WIDTH  read data, valid with req_done.
REQ-015 SHALL have port t_valid  out  1  transfer start to APB master.
REQ-016 SHALL have ports pwrite_in/psel_in/paddr_in/pwdata_in  out  1/2/ADDR_WIDTH/DATA_WIDTH  latched command to master.
REQ-017 SHALL have port m_ready  in  1  master setup-accepted indication.
REQ-018 SHALL have ports pready/prdata  in  1/DATA_WIDTH  slave completion and read data.
REQ-019 SHALL have ports busy  out  1 and grant_id  out  2  current owner.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, REJECT.
REQ-021 In IDLE with any req_valid, SHALL grant one requester round-robin: search starts at last_grant+1 mod 4.
REQ-022 On grant edge SHALL latch winner's write/psel/addr/wdata into command registers, set grant_id, update last_grant, pulse req_ack[winner] for exactly one cycle.
REQ-023 On grant with psel = 00, SHALL go to REJECT without driving t_valid; REJECT pulses req_done[g] with req_err=1, rdata=0, then returns to IDLE.
REQ-024 On grant with psel != 00, SHALL go to ISSUE; t_valid SHALL be high only during the first ISSUE cycle (single-cycle pulse per transfer).
REQ-025 Command outputs SHALL remain stable from grant until req_done.
REQ-026 In ISSUE, on m_ready=1 with pready=0, SHALL go to WAIT; with m_ready=1 and pready=1, SHALL complete directly.
REQ-027 In WAIT, on pready=1 SHALL complete; otherwise stay (no timeout).
REQ-028 Completion SHALL: capture prdata into rdata if read (hold previous rdata if write), pulse req_done[g] with req_err=0 the following cycle, go IDLE.
REQ-029 Earliest next grant SHALL be the cycle req_done is high; t_valid for it SHALL therefore never coincide with the previous transfer's access phase.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 req_valid deasserted before ack SHALL be ignored; simultaneous requests SHALL never cause two acks in one cycle.
REQ-032 pready outside ISSUE/WAIT SHALL be ignored.

Reset
REQ-033 prst SHALL force IDLE, last_grant=3 (requester 0 wins first), all outputs 0, from any state including mid-transfer; no req_done is issued for an aborted transfer.

Structure
REQ-034 State enum and default widths SHALL reside in shared package apb_pkg.
REQ-035 Round-robin selection SHALL be one sub-module rr_arbiter (req, last_grant -> one-hot grant, valid).

Verification
REQ-036 Single read: req_valid=0001, psel=01, addr=3, pready 2 cycles after m_ready, prdata=16'hBEEF -> one t_valid pulse, req_ack[0], req_done[0], rdata=BEEF, req_err=0.
REQ-037 All four requesting continuously -> grant order 0,1,2,3,0; exactly one t_valid per transfer.
REQ-038 Requester 2 with psel=00 -> req_ack[2] then req_done[2] with req_err=1, t_valid never asserted.
REQ-039 m_ready and pready high in same cycle -> completion without WAIT; write leaves rdata unchanged.
REQ-040 prst asserted while in WAIT -> next cycle IDLE, outputs 0, no req_done; next request from requester 0 granted first.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_pkg : shared state encoding and default widths for apb_req_arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package apb_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NREQ       = 4;
  localparam int PSEL_WIDTH     = 2;
  localparam int ID_WIDTH       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REJECT = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : 4-way round-robin pick, search starts at last_grant+1         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arbiter
  import apb_pkg::*;
(
  input  logic [DEF_NREQ-1:0] req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [DEF_NREQ-1:0] grant,
  output logic                valid
);

  logic [ID_WIDTH-1:0] w_idx;

  // First requester found walking upward from last_grant+1 (wrapping) wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= DEF_NREQ; k++) begin
      w_idx = last_grant + ID_WIDTH'(k);
      if (!valid && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_req_arbiter : round-robin front end sharing one APB master among 4 reqs|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NREQ       = DEF_NREQ
) (
  input  logic                         pclk,
  input  logic                         prst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_write,
  input  logic [PSEL_WIDTH*NREQ-1:0]   req_psel,
  input  logic [ADDR_WIDTH*NREQ-1:0]   req_addr,
  input  logic [DATA_WIDTH*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]              req_ack,
  output logic [NREQ-1:0]              req_done,
  output logic                         req_err,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         t_valid,
  output logic                         pwrite_in,
  output logic [PSEL_WIDTH-1:0]        psel_in,
  output logic [ADDR_WIDTH-1:0]        paddr_in,
  output logic [DATA_WIDTH-1:0]        pwdata_in,
  input  logic                         m_ready,
  input  logic                         pready,
  input  logic [DATA_WIDTH-1:0]        prdata,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          grant_id
);

  arb_state_t              r_state;
  arb_state_t              w_next_state;
  logic [ID_WIDTH-1:0]     r_last_grant;
  logic [NREQ-1:0]         w_arb_grant;
  logic                    w_arb_valid;
  logic                    w_grant;
  logic                    w_complete;
  logic [NREQ-1:0]         w_owner_onehot;
  logic [ID_WIDTH-1:0]     w_win_idx;
  logic                    w_win_write;
  logic [PSEL_WIDTH-1:0]   w_win_psel;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic [DATA_WIDTH-1:0]   w_win_wdata;

  rr_arbiter u_rr_arbiter (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_arb_grant),
    .valid      (w_arb_valid)
  );

  // Route the winning requester's command fields.
  always_comb begin
    w_win_idx   = '0;
    w_win_write = 1'b0;
    w_win_psel  = '0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_grant[i]) begin
        w_win_idx   = ID_WIDTH'(i);
        w_win_write = req_write[i];
        w_win_psel  = req_psel[PSEL_WIDTH*i +: PSEL_WIDTH];
        w_win_addr  = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        w_win_wdata = req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_owner_onehot           = '0;
    w_owner_onehot[grant_id] = 1'b1;
  end

  assign w_grant    = (r_state == ST_IDLE) && w_arb_valid;
  assign w_complete = ((r_state == ST_ISSUE) && m_ready && pready) ||
                      ((r_state == ST_WAIT) && pready);
  assign busy       = (r_state != ST_IDLE);

  always_ff @(posedge pclk) begin
    if (prst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_next_state = (w_win_psel == '0) ? ST_REJECT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (m_ready) begin
          w_next_state = pready ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (pready) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REJECT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Pulses default low every cycle; done is raised one cycle after completion.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_last_grant <= ID_WIDTH'(NREQ - 1);
      grant_id     <= '0;
      req_ack      <= '0;
      req_done     <= '0;
      req_err      <= 1'b0;
      rdata        <= '0;
      t_valid      <= 1'b0;
      pwrite_in    <= 1'b0;
      psel_in      <= '0;
      paddr_in     <= '0;
      pwdata_in    <= '0;
    end else begin
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= 1'b0;
      t_valid  <= 1'b0;
      if (w_grant) begin
        grant_id     <= w_win_idx;
        r_last_grant <= w_win_idx;
        req_ack      <= w_arb_grant;
        pwrite_in    <= w_win_write;
        psel_in      <= w_win_psel;
        paddr_in     <= w_win_addr;
        pwdata_in    <= w_win_wdata;
        t_valid      <= (w_win_psel != '0);
      end
      if (w_complete) begin
        req_done <= w_owner_onehot;
        if (!pwrite_in) begin
          rdata <= prdata;
        end
      end
      if (r_state == ST_REJECT) begin
        req_done <= w_owner_onehot;
        req_err  <= 1'b1;
        rdata    <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb_req_arbiter : directed self-checking bench for apb_req_arbiter      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_apb_req_arbiter;

  logic        pclk = 1'b0;
  logic        prst;
  logic [3:0]  req_valid, req_write;
  logic [7:0]  req_psel;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_ack, req_done;
  logic        req_err;
  logic [15:0] rdata;
  logic        t_valid, pwrite_in;
  logic [1:0]  psel_in;
  logic [3:0]  paddr_in;
  logic [15:0] pwdata_in;
  logic        m_ready, pready;
  logic [15:0] prdata;
  logic        busy;
  logic [1:0]  grant_id;

  int total = 0;
  int bad   = 0;
  int tv_cnt = 0;
  int done_cnt = 0;
  int ack_q[$];

  apb_req_arbiter dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write), .req_psel(req_psel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .rdata(rdata),
    .t_valid(t_valid), .pwrite_in(pwrite_in), .psel_in(psel_in),
    .paddr_in(paddr_in), .pwdata_in(pwdata_in),
    .m_ready(m_ready), .pready(pready), .prdata(prdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 pclk = ~pclk;

  // Event log sampled at the rising edge (sees the values of the cycle just ended).
  always @(posedge pclk) begin
    for (int i = 0; i < 4; i++) if (req_ack[i]) ack_q.push_back(i);
    if (t_valid) tv_cnt++;
    if (req_done != 4'b0) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
  endtask

  int tv0, dn0, aq0, found;

  initial begin
    prst = 1'b1; req_valid = '0; req_write = '0; req_psel = '0; req_addr = '0;
    req_wdata = '0; m_ready = 1'b0; pready = 1'b0; prdata = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_done", req_done, 0);
    chk("rst_tvalid", t_valid, 0);
    chk("rst_rdata", rdata, 0);
    prst = 1'b0;

    // Single read from requester 0, pready two cycles after m_ready.
    tv0 = tv_cnt;
    req_valid = 4'b0001; req_psel[1:0] = 2'b01; req_addr[3:0] = 4'd3;
    tick();
    chk("rd_ack", req_ack, 4'b0001);
    chk("rd_tvalid", t_valid, 1);
    chk("rd_gid", grant_id, 0);
    chk("rd_addr", paddr_in, 3);
    chk("rd_psel", psel_in, 1);
    chk("rd_busy", busy, 1);
    req_valid = '0; m_ready = 1'b1;
    tick();
    chk("rd_tv_pulse", t_valid, 0);
    chk("rd_ack_pulse", req_ack, 0);
    m_ready = 1'b0;
    tick();
    chk("rd_wait_busy", busy, 1);
    pready = 1'b1; prdata = 16'hBEEF;
    tick();
    chk("rd_done", req_done, 4'b0001);
    chk("rd_err", req_err, 0);
    chk("rd_rdata", rdata, 16'hBEEF);
    chk("rd_idle", busy, 0);
    pready = 1'b0; prdata = 16'h0;
    tick();
    chk("rd_done_pulse", req_done, 0);
    chk("rd_tv_count", tv_cnt - tv0, 1);

    // Write from requester 1 with m_ready and pready together.
    req_valid = 4'b0010; req_write[1] = 1'b1; req_psel[3:2] = 2'b10;
    req_addr[7:4] = 4'd5; req_wdata[31:16] = 16'h1234;
    tick();
    chk("wr_ack", req_ack, 4'b0010);
    chk("wr_gid", grant_id, 1);
    chk("wr_pwrite", pwrite_in, 1);
    chk("wr_psel", psel_in, 2);
    chk("wr_wdata", pwdata_in, 16'h1234);
    req_valid = '0; m_ready = 1'b1; pready = 1'b1; prdata = 16'h5555;
    tick();
    chk("wr_done", req_done, 4'b0010);
    chk("wr_rdata_hold", rdata, 16'hBEEF);
    chk("wr_no_wait", busy, 0);
    m_ready = 1'b0; pready = 1'b0;

    // Requester 2 with psel=00 is rejected without t_valid.
    tv0 = tv_cnt;
    req_valid = 4'b0100; req_psel[5:4] = 2'b00;
    tick();
    chk("rej_ack", req_ack, 4'b0100);
    chk("rej_tvalid", t_valid, 0);
    chk("rej_busy", busy, 1);
    req_valid = '0;
    tick();
    chk("rej_done", req_done, 4'b0100);
    chk("rej_err", req_err, 1);
    chk("rej_rdata", rdata, 0);
    // Stray pready while idle must be ignored.
    pready = 1'b1;
    tick();
    chk("rej_tv_count", tv_cnt - tv0, 0);
    tick();
    chk("idle_pready_done", req_done, 0);
    chk("idle_pready_busy", busy, 0);
    pready = 1'b0;

    // Round robin after reset with everyone requesting.
    prst = 1'b1; tick(); prst = 1'b0;
    tv0 = tv_cnt; dn0 = done_cnt; aq0 = ack_q.size();
    req_valid = 4'b1111; req_psel = 8'h55; req_write = '0;
    m_ready = 1'b1; pready = 1'b1;
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      tick();
      chk("rr_one_ack", $countones(req_ack) <= 1, 1);
      if (ack_q.size() - aq0 >= 5) found = 1;
    end
    chk("rr_timeout", found, 1);
    req_valid = '0;
    repeat (4) tick();
    if (found == 1) begin
      for (int j = 0; j < 5; j++) chk($sformatf("rr_order%0d", j), ack_q[aq0 + j], j % 4);
    end
    chk("rr_tv_per_xfer", tv_cnt - tv0, ack_q.size() - aq0);
    chk("rr_done_per_xfer", done_cnt - dn0, ack_q.size() - aq0);
    m_ready = 1'b0; pready = 1'b0;

    // Reset while waiting on pready aborts without a done.
    req_valid = 4'b1000; req_psel[7:6] = 2'b11; req_addr[15:12] = 4'hA;
    tick();
    chk("ab_ack", req_ack, 4'b1000);
    chk("ab_gid", grant_id, 3);
    req_valid = '0; m_ready = 1'b1;
    tick();
    chk("ab_wait_busy", busy, 1);
    m_ready = 1'b0; prst = 1'b1; dn0 = done_cnt;
    tick();
    chk("ab_busy", busy, 0);
    chk("ab_done", req_done, 0);
    chk("ab_gid0", grant_id, 0);
    chk("ab_psel0", psel_in, 0);
    chk("ab_addr0", paddr_in, 0);
    chk("ab_rdata0", rdata, 0);
    prst = 1'b0; pready = 1'b1;
    tick();
    chk("ab_no_done", req_done, 0);
    pready = 1'b0; req_valid = 4'b1111; req_psel = 8'h55;
    tick();
    chk("ab_first_req0", req_ack, 4'b0001);
    req_valid = '0; m_ready = 1'b1; pready = 1'b1; prdata = 16'h0BAD;
    tick();
    chk("ab_next_done", req_done, 4'b0001);
    chk("ab_next_rdata", rdata, 16'h0BAD);
    m_ready = 1'b0; pready = 1'b0;
    tick();
    chk("ab_done_count", done_cnt - dn0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
